ramp_sweep_ctrl: RTL and testbench
==================================

// Module: ramp_sweep_ctrl
// PURPOSE
//  Sweep sequencer for the ramp sawtooth generator. Steps the generator's frequency code
//  through a programmed index range, holding each step for a dwell time with a short
//  off-gap between steps so every step starts from phase 0. Sits between the control
//  register file and the ramp generator; drives its on/frequency/amplitude inputs.
// PARAMETERS
//  DWELL_W    32  width of dwell counter / dwell input
//  GAP_CYCLES 16  cycles gen_on is held low between steps (>=1)
//  IDX_MAX    13  highest valid step index; code(idx) = (16'h1 << idx) - 1
// PORTS
//  clk            in   1        system clock, 50 MHz
//  rst_n          in   1        asynchronous reset, active low
//  start          in   1        1-cycle request to begin sweep (accepted only in IDLE)
//  stop           in   1        1-cycle abort request
//  loop_en        in   1        1: repeat sweep until stop; 0: single pass
//  idx_first      in   4        first step index
//  idx_last       in   4        last step index
//  dwell          in   DWELL_W  cycles gen_on is high per step
//  amp_in         in   8        amplitude in %, forwarded per sweep
//  busy           out  1        high in every state except IDLE
//  done           out  1        1-cycle pulse on normal completion
//  step_idx       out  4        current step index
//  gen_on         out  1        to generator 'on'
//  gen_frequency  out  16       to generator 'frequency'
//  gen_amplitude  out  8        to generator 'amplitude'
// BEHAVIOUR
//  - All outputs registered. Reset (async): state IDLE, busy=0, done=0, step_idx=0,
//    gen_on=0, gen_frequency=16'h0000, gen_amplitude=0, counters=0. Reset mid-sweep
//    aborts immediately, no done pulse.
//  - States: IDLE, LOAD, RUN, GAP, DONE.
//  - IDLE: start=1 & stop=0 -> LOAD; latch idx_first/idx_last (values >IDX_MAX clamp
//    to IDX_MAX), loop_en, dwell (0 treated as 1), amp_in. Inputs ignored outside IDLE.
//  - Direction: up if first<=last, else down (decrement). first==last -> single step.
//  - LOAD (1 cycle): step_idx=first, gen_frequency=code(first), gen_amplitude=latched
//    amp, busy=1, gen_on=0 -> RUN. start at cycle T => gen_on=1 visible at T+2.
//  - RUN: gen_on=1 for exactly dwell cycles. On last cycle:
//      not at last index -> GAP, advance step_idx by +/-1;
//      at last index & loop -> GAP, step_idx=first;
//      at last index & !loop -> DONE.
//  - GAP: gen_on=0 for GAP_CYCLES cycles; gen_frequency updates to code(step_idx) on
//    GAP entry -> RUN. gen_frequency never changes while gen_on=1.
//  - DONE (1 cycle): done=1, gen_on=0, busy=1 -> IDLE (busy=0, gen_frequency kept).
//  - stop=1 in any non-IDLE state: next cycle IDLE, gen_on=0, busy=0, no done.
//    stop has priority over start and over step advance in the same cycle.
//  - Dwell and gap counters saturate-free: reload on every state entry; no wrap.
// CONFIGURATION
//  PINGPONG_EN (`define): defined -> in loop mode at the last index the direction
//  reverses and the sweep walks back to first, endpoints not repeated (0,1,2,1,0,1..);
//  first==last behaves as without. Undefined -> loop jumps back to first (0,1,2,0,1,2..).
//  Single-pass mode identical in both builds.
// TESTING
//  1 reset: rst_n=0 mid-RUN -> all outputs 0 same cycle, IDLE after release.
//  2 first=0,last=2,dwell=5,loop=0,start@T -> gen_on high T+2..T+6, freq 0000,
//    gap 16 cyc, then 0001, 0003; done pulse 1 cycle after last dwell; busy low after.
//  3 first=3,last=1,dwell=3 -> freq 0007,0003,0001 sequence; done once.
//  4 loop=1,first=0,last=2,dwell=2 -> step_idx 0,1,2,0,1 (PINGPONG_EN: 0,1,2,1,0);
//    stop mid-RUN -> gen_on=0 & busy=0 next cycle, no done.
//  5 idx_last=15 -> clamped, final freq 1FFF; dwell=0 -> gen_on high 1 cycle/step.
//  6 start+stop same cycle in IDLE -> stays IDLE; start while busy -> ignored.

Source files
------------

// File: rtl/ramp_sweep_ctrl.sv
// Sweep sequencer for the ramp sawtooth generator.
// Walks the generator frequency code through a latched index range, holding
// each step for a dwell time and inserting an off-gap between steps so every
// step restarts the generator from phase 0.
// Build option: define PINGPONG_EN to make loop mode bounce between the range
// endpoints instead of jumping back to the first index.
module ramp_sweep_ctrl #(
  parameter int DWELL_W    = 32,
  parameter int GAP_CYCLES = 16,
  parameter int IDX_MAX    = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [3:0]         idx_first,
  input  logic [3:0]         idx_last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         amp_in,
  output logic               busy,
  output logic               done,
  output logic [3:0]         step_idx,
  output logic               gen_on,
  output logic [15:0]        gen_frequency,
  output logic [7:0]         gen_amplitude
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;

  state_t             state_q, state_nx;
  logic [DWELL_W-1:0] cnt_q, cnt_nx;
  logic [DWELL_W-1:0] dwell_q, dwell_nx;
  logic [3:0]         first_q, first_nx;
  logic [3:0]         last_q, last_nx;
  logic               loop_q, loop_nx;
  logic               up_q, up_nx;
  logic [3:0]         idx_nx;
  logic [15:0]        freq_nx;
  logic [7:0]         amp_nx;
  logic               inc;
  logic [3:0]         target;
`ifdef PINGPONG_EN
  logic               fwd_q, fwd_nx;
`endif

  // Indices beyond the top of the code table clamp to the highest valid index.
  function automatic logic [3:0] clamp_idx(input logic [3:0] v);
    return (v > 4'(IDX_MAX)) ? 4'(IDX_MAX) : v;
  endfunction

  // Generator frequency code for a step index: all ones below bit idx.
  function automatic logic [15:0] idx_code(input logic [3:0] i);
    return (16'h1 << i) - 16'h1;
  endfunction

  function automatic logic [3:0] step_toward(input logic [3:0] i, input logic up);
    return up ? i + 4'd1 : i - 4'd1;
  endfunction

  // State, counter, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      dwell_q       <= '0;
      first_q       <= '0;
      last_q        <= '0;
      loop_q        <= 1'b0;
      up_q          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      gen_on        <= 1'b0;
      step_idx      <= '0;
      gen_frequency <= '0;
      gen_amplitude <= '0;
`ifdef PINGPONG_EN
      fwd_q         <= 1'b1;
`endif
    end else begin
      state_q       <= state_nx;
      cnt_q         <= cnt_nx;
      dwell_q       <= dwell_nx;
      first_q       <= first_nx;
      last_q        <= last_nx;
      loop_q        <= loop_nx;
      up_q          <= up_nx;
      busy          <= (state_nx != S_IDLE);
      done          <= (state_nx == S_DONE);
      gen_on        <= (state_nx == S_RUN);
      step_idx      <= idx_nx;
      gen_frequency <= freq_nx;
      gen_amplitude <= amp_nx;
`ifdef PINGPONG_EN
      fwd_q         <= fwd_nx;
`endif
    end
  end

  // Next state, next step index/frequency and counter reloads; stop overrides all.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    dwell_nx = dwell_q;
    first_nx = first_q;
    last_nx  = last_q;
    loop_nx  = loop_q;
    up_nx    = up_q;
    idx_nx   = step_idx;
    freq_nx  = gen_frequency;
    amp_nx   = gen_amplitude;
`ifdef PINGPONG_EN
    fwd_nx   = fwd_q;
    inc      = fwd_q ? up_q : !up_q;
    target   = fwd_q ? last_q : first_q;
`else
    inc      = up_q;
    target   = last_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_nx = S_LOAD;
          first_nx = clamp_idx(idx_first);
          last_nx  = clamp_idx(idx_last);
          up_nx    = (clamp_idx(idx_first) <= clamp_idx(idx_last));
          loop_nx  = loop_en;
          dwell_nx = (dwell == '0) ? DWELL_W'(1) : dwell;
          idx_nx   = clamp_idx(idx_first);
          freq_nx  = idx_code(clamp_idx(idx_first));
          amp_nx   = amp_in;
`ifdef PINGPONG_EN
          fwd_nx   = 1'b1;
`endif
        end
      end
      S_LOAD: begin
        state_nx = S_RUN;
        cnt_nx   = dwell_q - DWELL_W'(1);
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_nx = cnt_q - DWELL_W'(1);
        end else if (step_idx != target) begin
          state_nx = S_GAP;
          cnt_nx   = DWELL_W'(GAP_CYCLES - 1);
          idx_nx   = step_toward(step_idx, inc);
          freq_nx  = idx_code(idx_nx);
        end else if (loop_q) begin
          state_nx = S_GAP;
          cnt_nx   = DWELL_W'(GAP_CYCLES - 1);
`ifdef PINGPONG_EN
          if (first_q == last_q) begin
            idx_nx = first_q;
          end else begin
            fwd_nx = !fwd_q;
            idx_nx = step_toward(step_idx, !inc);
          end
`else
          idx_nx   = first_q;
`endif
          freq_nx  = idx_code(idx_nx);
        end else begin
          state_nx = S_DONE;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_nx = cnt_q - DWELL_W'(1);
        end else begin
          state_nx = S_RUN;
          cnt_nx   = dwell_q - DWELL_W'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      idx_nx   = step_idx;
      freq_nx  = gen_frequency;
    end
  end

endmodule

// File: tb/tb_ramp_sweep_ctrl.sv
// Randomized and directed bench for ramp_sweep_ctrl against a step-list model.
module tb_ramp_sweep_ctrl;
  localparam int DWELL_W = 32;
  localparam int GAP     = 16;
  localparam int IMAX    = 13;

  typedef struct packed {
    logic        on;
    logic [15:0] f;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
  } samp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               loop_en = 1'b0;
  logic [3:0]         idx_first = '0;
  logic [3:0]         idx_last = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [7:0]         amp_in = '0;
  logic               busy, done, gen_on;
  logic [3:0]         step_idx;
  logic [15:0]        gen_frequency;
  logic [7:0]         gen_amplitude;

  int    n_assert = 0;
  int    n_fail   = 0;
  samp_t exp_q[$];

  always #10 clk = ~clk;

  ramp_sweep_ctrl #(.DWELL_W(DWELL_W), .GAP_CYCLES(GAP), .IDX_MAX(IMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .idx_first(idx_first), .idx_last(idx_last), .dwell(dwell), .amp_in(amp_in),
    .busy(busy), .done(done), .step_idx(step_idx), .gen_on(gen_on),
    .gen_frequency(gen_frequency), .gen_amplitude(gen_amplitude)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input samp_t e, input logic [7:0] amp);
    chk({tag, ".gen_on"}, 32'(gen_on), 32'(e.on));
    chk({tag, ".freq"}, 32'(gen_frequency), 32'(e.f));
    chk({tag, ".step_idx"}, 32'(step_idx), 32'(e.idx));
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    chk({tag, ".done"}, 32'(done), 32'(e.done));
    chk({tag, ".amp"}, 32'(gen_amplitude), 32'(amp));
  endtask

  function automatic logic [15:0] code_of(input int i);
    return 16'((1 << i) - 1);
  endfunction

  function automatic samp_t mk(input logic on, input int i, input logic b, input logic d);
    samp_t s;
    s.on = on; s.f = code_of(i); s.idx = 4'(i); s.busy = b; s.done = d;
    return s;
  endfunction

  // Expected per-cycle trace from the step list: load, dwell, gap, ..., done, idle.
  task automatic build_trace(input int f, input int l, input int dw, input bit lp);
    int r[$];
    int pat[$];
    int steps[$];
    int d;
    r.delete(); pat.delete(); steps.delete(); exp_q.delete();
    if (f > IMAX) f = IMAX;
    if (l > IMAX) l = IMAX;
    d = (dw == 0) ? 1 : dw;
    if (f <= l) for (int i = f; i <= l; i++) r.push_back(i);
    else        for (int i = f; i >= l; i--) r.push_back(i);
    foreach (r[i]) pat.push_back(r[i]);
`ifdef PINGPONG_EN
    for (int i = r.size() - 2; i >= 1; i--) pat.push_back(r[i]);
`endif
    if (!lp) foreach (r[i]) steps.push_back(r[i]);
    else while (steps.size() < 2 * r.size() + 2) foreach (pat[i]) steps.push_back(pat[i]);
    exp_q.push_back(mk(1'b0, steps[0], 1'b1, 1'b0));
    for (int s = 0; s < steps.size(); s++) begin
      for (int c = 0; c < d; c++) exp_q.push_back(mk(1'b1, steps[s], 1'b1, 1'b0));
      if (s < steps.size() - 1)
        for (int c = 0; c < GAP; c++) exp_q.push_back(mk(1'b0, steps[s+1], 1'b1, 1'b0));
    end
    if (!lp) begin
      exp_q.push_back(mk(1'b0, steps[steps.size()-1], 1'b1, 1'b1));
      exp_q.push_back(mk(1'b0, steps[steps.size()-1], 1'b0, 1'b0));
    end
  endtask

  // Start a sweep and follow the trace; stop_at < 0 means run to completion.
  task automatic run_sweep(input string tag, input int f, input int l, input int dw,
                           input bit lp, input logic [7:0] amp, input int stop_at);
    samp_t e;
    build_trace(f, l, dw, lp);
    idx_first = 4'(f); idx_last = 4'(l); dwell = DWELL_W'(dw); loop_en = lp; amp_in = amp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk_all(tag, exp_q[k], amp);
      if (k == stop_at) begin
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop  = 1'b0;
        e = exp_q[k];
        e.on = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        chk_all({tag, ".stopped"}, e, amp);
        tick();
        chk_all({tag, ".idle"}, e, amp);
        break;
      end
      // Inputs churn while busy; the sweep must ignore them.
      start     = exp_q[k].busy ? 1'($urandom_range(0, 1)) : 1'b0;
      idx_first = 4'($urandom);
      idx_last  = 4'($urandom);
      dwell     = DWELL_W'($urandom_range(0, 9));
      loop_en   = 1'($urandom);
      amp_in    = 8'($urandom);
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    samp_t zero;
    zero = '0;

    // Reset values
    tick(); tick();
    chk_all("reset", zero, 8'h00);
    rst_n = 1'b1;
    tick();
    chk_all("post_reset", zero, 8'h00);

    // Async reset in the middle of a dwell
    idx_first = 4'd0; idx_last = 4'd2; dwell = 5; loop_en = 1'b0; amp_in = 8'h55;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("mid_run.gen_on", 32'(gen_on), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_reset", zero, 8'h00);
    tick();
    #1 rst_n = 1'b1;
    tick();
    chk_all("after_reset", zero, 8'h00);

    // Directed sweeps
    run_sweep("up_0_2",   0, 2, 5, 1'b0, 8'd40, -1);
    run_sweep("down_3_1", 3, 1, 3, 1'b0, 8'd75, -1);
    run_sweep("loop_0_2", 0, 2, 2, 1'b1, 8'd20, 60);
    run_sweep("clamp",   11, 15, 0, 1'b0, 8'd99, -1);
    chk("clamp.final_freq", 32'(gen_frequency), 32'h1FFF);
    run_sweep("single",   7, 7, 1, 1'b0, 8'd10, -1);
    run_sweep("stop_load", 2, 5, 2, 1'b0, 8'd33, 0);

    // start and stop together in IDLE: nothing happens
    idx_first = 4'd1; idx_last = 4'd4; dwell = 2; amp_in = 8'hAA;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop.busy", 32'(busy), 32'd0);
    chk("start_stop.gen_on", 32'(gen_on), 32'd0);
    chk("start_stop.amp", 32'(gen_amplitude), 32'(8'd33));
    tick();
    chk("start_stop.busy2", 32'(busy), 32'd0);

    // Randomized sweeps
    for (int n = 0; n < 10; n++) begin
      int  f, l, dw, sa;
      bit  lp;
      f  = $urandom_range(0, 15);
      l  = $urandom_range(0, 15);
      if (((f > IMAX) ? IMAX : f) > ((l > IMAX) ? IMAX : l) + 5) l = f - 5;
      if (((l > IMAX) ? IMAX : l) > ((f > IMAX) ? IMAX : f) + 5) l = f + 5;
      dw = $urandom_range(0, 4);
      lp = 1'($urandom);
      build_trace(f, l, dw, lp);
      if (lp) sa = $urandom_range(1, exp_q.size() - 1);
      else    sa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, exp_q.size() - 1) : -1;
      run_sweep($sformatf("rand%0d", n), f, l, dw, lp, 8'($urandom), sa);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
